// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer. It walks RESP_BITS challenges starting at a
// latched base. For each challenge it runs VOTES settle/fire/sample trials and
// takes a majority vote of the synchronized arbiter output. The assembled word
// is then offered on a valid/ready handshake.
module puf_challenge_sequencer #(
    parameter int CHAL_W     = 3,
    parameter int RESP_BITS  = 8,
    parameter int VOTES      = 3,
    parameter int SETTLE_CYC = 4,
    parameter int PULSE_CYC  = 2
) (
    input  logic                 iclk,
    input  logic                 irst_n,
    input  logic                 istart,
    input  logic                 iabort,
    input  logic [CHAL_W-1:0]    ibase_challenge,
    input  logic                 iarb_resp,
    output logic [CHAL_W-1:0]    ochallange,
    output logic                 opulse,
    output logic [RESP_BITS-1:0] oresp,
    output logic                 oresp_valid,
    input  logic                 iresp_ready,
    output logic                 obusy
);

    localparam int SAMPLE_CYC = 3;
    localparam int CNT_MAX = (SETTLE_CYC > PULSE_CYC) ?
                             ((SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC) :
                             ((PULSE_CYC > SAMPLE_CYC) ? PULSE_CYC : SAMPLE_CYC);
    localparam int CW = $clog2(CNT_MAX);
    localparam int KW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int TW = (VOTES > 1) ? $clog2(VOTES) : 1;
    localparam int VW = $clog2(VOTES + 1);

    typedef enum logic [2:0] {IDLE, SETTLE, FIRE, SAMPLE, DONE} state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic [KW-1:0] k;
    logic [TW-1:0] t;
    logic [VW-1:0] v;
    logic [VW-1:0] vsum;
    logic          sync1, sync2;
    logic          accept, trial_end, last_trial, last_bit;

    assign accept     = (state == IDLE) && istart && !iabort;
    assign trial_end  = (state == SAMPLE) && (cnt == CW'(SAMPLE_CYC - 1));
    assign last_trial = (t == TW'(VOTES - 1));
    assign last_bit   = (k == KW'(RESP_BITS - 1));
    assign vsum       = v + VW'(sync2);
    assign obusy      = (state != IDLE);

    // State register
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state logic; abort overrides every active state
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (accept) next_state = SETTLE;
            SETTLE: if (cnt == CW'(SETTLE_CYC - 1)) next_state = FIRE;
            FIRE:   if (cnt == CW'(PULSE_CYC - 1)) next_state = SAMPLE;
            SAMPLE: if (trial_end) next_state = (last_trial && last_bit) ? DONE : SETTLE;
            DONE:   if (oresp_valid && iresp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (state != IDLE && iabort) next_state = IDLE;
    end

    // Two-flop synchronizer for the asynchronous arbiter output
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= iarb_resp;
            sync2 <= sync1;
        end
    end

    // Registered outputs: pulse is high exactly in FIRE; valid rises one
    // cycle after entering DONE and drops on handshake or abort
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            opulse      <= 1'b0;
            oresp_valid <= 1'b0;
        end else begin
            opulse      <= (next_state == FIRE);
            oresp_valid <= (state == DONE) && (next_state == DONE);
        end
    end

    // Phase counter, trial/vote/bit counters, challenge and response word
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            cnt        <= '0;
            k          <= '0;
            t          <= '0;
            v          <= '0;
            ochallange <= '0;
            oresp      <= '0;
        end else begin
            if (next_state != state || state == IDLE || state == DONE) cnt <= '0;
            else                                                      cnt <= cnt + 1'b1;

            if (accept) begin
                ochallange <= ibase_challenge;
                oresp      <= '0;
                k          <= '0;
                t          <= '0;
                v          <= '0;
            end else if (state != IDLE && iabort) begin
                k <= '0;
                t <= '0;
                v <= '0;
            end else if (trial_end) begin
                if (last_trial) begin
                    oresp[k] <= (vsum > VW'(VOTES / 2));
                    t        <= '0;
                    v        <= '0;
                    if (!last_bit) begin
                        k          <= k + 1'b1;
                        ochallange <= ochallange + 1'b1;
                    end
                end else begin
                    t <= t + 1'b1;
                    v <= vsum;
                end
            end
        end
    end

endmodule

// File: doc/puf_challenge_sequencer.md
PUF_CHALLENGE_SEQUENCER -- requirements
Module: puf_challenge_sequencer

Interface
REQ-001 SHALL have parameter CHAL_W, default 3, challenge width; matches delay-line stage count.
REQ-002 SHALL have parameter RESP_BITS, default 8, response bits per request.
REQ-003 SHALL have parameter VOTES, default 3, trials per bit; odd, >=1.
REQ-004 SHALL have parameter SETTLE_CYC, default 4, low-pulse settle cycles per trial; >=1.
REQ-005 SHALL have parameter PULSE_CYC, default 2, cycles opulse held high per trial; >=1.
REQ-006 iclk  in  1  sole clock; all state changes on rising edge.
REQ-007 irst_n  in  1  reset; asynchronous, active-low.
REQ-008 istart  in  1  request a response word; sampled only in IDLE.
REQ-009 iabort  in  1  synchronous abort of a running request.
REQ-010 ibase_challenge  in  CHAL_W  base challenge, latched on accepted istart.
REQ-011 iarb_resp  in  1  arbiter output; asynchronous to iclk.
REQ-012 ochallange  out  CHAL_W  challenge driven to the delay line.
REQ-013 opulse  out  1  launch pulse driven to the delay line.
REQ-014 oresp  out  RESP_BITS  assembled response word.
REQ-015 oresp_valid  out  1  oresp valid; held until accepted.
REQ-016 iresp_ready  in  1  consumer accepts oresp when high with oresp_valid.
REQ-017 obusy  out  1  high in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, SETTLE, FIRE, SAMPLE, DONE.
REQ-019 IDLE: istart=1 and iabort=0 -> latch base, clear oresp, bit index k=0, trial count t=0, vote count v=0, go SETTLE.
REQ-020 SETTLE: opulse=0 for SETTLE_CYC cycles, then FIRE.
REQ-021 FIRE: opulse=1 for PULSE_CYC cycles, then SAMPLE.
REQ-022 SAMPLE: opulse=0 for 3 cycles; iarb_resp passes a 2-flop synchronizer; synchronizer output sampled on the 3rd cycle; v increments if it is 1.
REQ-023 After SAMPLE, t<VOTES-1 -> t+1, SETTLE; else bit k = (v > VOTES/2), written to oresp[k], v and t cleared.
REQ-024 After bit k is written, k<RESP_BITS-1 -> k+1, SETTLE; else DONE.
REQ-025 ochallange SHALL equal (base + k) mod 2^CHAL_W during SETTLE, FIRE and SAMPLE, wrapping with no carry-out; SHALL be stable throughout each trial.
REQ-026 Accept-edge to oresp_valid rising latency SHALL be RESP_BITS*VOTES*(SETTLE_CYC+PULSE_CYC+3)+1 cycles (217 at defaults).
REQ-027 DONE: oresp_valid=1, oresp stable; iresp_ready=1 -> IDLE next cycle with oresp_valid=0. iresp_ready may be high before valid.
REQ-028 Outside DONE, oresp_valid SHALL be 0.
REQ-029 istart outside IDLE SHALL be ignored, with no queuing.
REQ-030 iabort=1 in any non-IDLE state -> IDLE next cycle; opulse=0, oresp_valid=0, partial oresp retained, counters cleared.
REQ-031 Simultaneous istart and iabort in IDLE SHALL stay in IDLE; iabort has priority.
REQ-032 iabort in DONE SHALL discard the word (oresp_valid drops) and return to IDLE.
REQ-033 opulse SHALL be 0 in IDLE and DONE.
REQ-034 opulse SHALL be registered and glitch-free.

Reset
REQ-035 irst_n low SHALL immediately force IDLE, and set opulse=0, oresp_valid=0, obusy=0, oresp=0, ochallange=0, counters=0 and synchronizer flops=0, including mid-trial.
REQ-036 After irst_n deasserts, the first istart SHALL be accepted on the first rising edge at which it is seen in IDLE.

Verification
REQ-037 Defaults; base=3'd2; iarb_resp tied 1 -> oresp_valid rises 217 cycles after accept; oresp=8'hFF; ochallange sequence 2,3,4,5,6,7,0,1.
REQ-038 Base=3'd0; iarb_resp=1 only for challenge 5 and 6 -> oresp=8'h60.
REQ-039 Voting: for bit 0, iarb_resp=1 in trials 1 and 3 and 0 in trial 2; all other bits 0 -> oresp[0]=1. Then trials 1,2=0 and trial 3=1 -> oresp[0]=0.
REQ-040 iresp_ready held low 10 cycles in DONE -> oresp_valid and oresp stable for all 10 cycles; one cycle of ready -> IDLE with valid=0; istart during run ignored (only one word produced).
REQ-041 iabort asserted while opulse=1 -> next cycle opulse=0, obusy=0, no valid; istart+iabort together in IDLE -> stays IDLE.
REQ-042 irst_n pulsed low mid-FIRE -> opulse=0 immediately (asynchronously); all outputs at reset values; a subsequent full run matches REQ-037.
